// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register array. It merges in-order pipeline
// writebacks with buffered multi-cycle results, tracks pending multi-cycle
// destinations for decode hazard checks, and stalls the pipeline when a
// buffered result has waited too long.
module reg_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PIPE_WB_VALID,
  input  logic [4:0]  PIPE_WB_RD,
  input  logic [31:0] PIPE_WB_DATA,
  output logic        PIPE_STALL,
  input  logic        MC_VALID,
  input  logic [4:0]  MC_RD,
  input  logic [31:0] MC_DATA,
  output logic        MC_READY,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  RS1_SEL,
  input  logic [4:0]  RS2_SEL,
  output logic        HAZARD_RS1,
  output logic        HAZARD_RS2,
  output logic [31:0] BUSY_MASK,
  output logic        WB_VALID,
  output logic [4:0]  WB_RD,
  output logic [31:0] WB_DATA
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [4:0]       fifo_rd   [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
  logic [31:0]      busy_mask, busy_next;

  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        grant;
  logic [4:0]  grant_rd, head_rd;
  logic [31:0] grant_data, head_data;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == DEPTH);
  assign MC_READY   = !fifo_full;
  assign push       = MC_VALID && !fifo_full;
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign PIPE_STALL = (starve_cnt == LIMIT) && !fifo_empty;

  assign BUSY_MASK  = busy_mask;
  assign HAZARD_RS1 = (RS1_SEL != 5'd0) && busy_mask[RS1_SEL];
  assign HAZARD_RS2 = (RS2_SEL != 5'd0) && busy_mask[RS2_SEL];

  // Grant selection: starving FIFO head, then pipeline, then FIFO head.
  always_comb begin
    grant      = 1'b0;
    pop        = 1'b0;
    grant_rd   = 5'd0;
    grant_data = 32'd0;
    if (PIPE_STALL) begin
      grant      = 1'b1;
      pop        = 1'b1;
      grant_rd   = head_rd;
      grant_data = head_data;
    end else if (PIPE_WB_VALID) begin
      grant      = 1'b1;
      grant_rd   = PIPE_WB_RD;
      grant_data = PIPE_WB_DATA;
    end else if (!fifo_empty) begin
      grant      = 1'b1;
      pop        = 1'b1;
      grant_rd   = head_rd;
      grant_data = head_data;
    end
  end

  // Starvation count; once stalled, the count stays saturated so the whole
  // backlog drains back-to-back and the stall releases only when empty.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (fifo_empty || (pop && !PIPE_STALL)) begin
      starve_cnt_next = '0;
    end else if (!pop && (starve_cnt != LIMIT)) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  // Busy-mask update: clear on pop, set on issue (set wins), bit 0 never set.
  always_comb begin
    busy_next = busy_mask;
    if (pop && (head_rd != 5'd0)) begin
      busy_next[head_rd] = 1'b0;
    end
    if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
      busy_next[ISSUE_RD] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // FIFO storage; contents are meaningless while not counted in occ.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= MC_RD;
      fifo_data[wr_ptr] <= MC_DATA;
    end
  end

  // FIFO pointers, occupancy, starvation counter and busy mask.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      starve_cnt <= '0;
      busy_mask  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      starve_cnt <= starve_cnt_next;
      busy_mask  <= busy_next;
    end
  end

  // Registered write port; writes to x0 are consumed silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WB_VALID <= 1'b0;
      WB_RD    <= 5'd0;
      WB_DATA  <= 32'd0;
    end else begin
      WB_VALID <= grant && (grant_rd != 5'd0);
      if (grant) begin
        WB_RD   <= grant_rd;
        WB_DATA <= grant_data;
      end
    end
  end

endmodule
